// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Optional macro MIPS_CTRL_MEM_READY_EN: FETCH, MEMRD and MEMWR wait for mem_ready.
module mips_multicycle_ctrl #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            pc_write_cond_ne,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic [OP_W-1:0] alu_op,
  output logic            instr_done,
  output logic            illegal_op
);

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_ILLEGAL
  } state_e;

  typedef struct packed {
    logic            pc_write;
    logic            pc_write_cond;
    logic            pc_write_cond_ne;
    logic            i_or_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      pc_source;
    logic [OP_W-1:0] alu_op;
    logic            instr_done;
    logic            illegal_op;
  } ctrl_t;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  ctrl_t           ctrl_q;
  logic            stall;

`ifdef MIPS_CTRL_MEM_READY_EN
  assign stall = ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign stall            = 1'b0;
`endif

  function automatic ctrl_t decode_ctrl(input state_e s, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
                       c.alu_src_b = 2'b01; c.alu_op = OP_ADDI; end
      S_DECODE:  begin c.alu_src_b = 2'b11; c.alu_op = OP_ADDI; end
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = OP_LW; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = 1'b1; end
      S_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = OP_RTYPE; end
      S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_op = op; c.pc_source = 2'b01;
                       c.instr_done = 1'b1;
                       c.pc_write_cond    = (op == OP_BEQ);
                       c.pc_write_cond_ne = (op == OP_BNE); end
      S_IEXEC:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op; end
      S_IWB:     begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
      S_ILLEGAL: c.illegal_op = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = stall ? S_FETCH : S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ANDI,
          OP_ORI, OP_SLTI, OP_SLTIU: state_d = S_IEXEC;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = stall ? S_MEMRD : S_MEMWB;
      S_MEMWR:  state_d = stall ? S_MEMWR : S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: outputs are registered by decoding the *next* state, so they line up with
  // state_q in the same cycle without any combinational path from opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      op_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= decode_ctrl(state_d, op_d);
    end
  end

  // While memory stalls, the IR/PC loads and MEMWR's completion wait for mem_ready.
  assign ir_write         = ctrl_q.ir_write & ~stall;
  assign pc_write         = ctrl_q.pc_write & ~(stall & (state_q == S_FETCH));
  assign instr_done       = ctrl_q.instr_done & ~(stall & (state_q == S_MEMWR));
  assign pc_write_cond    = ctrl_q.pc_write_cond;
  assign pc_write_cond_ne = ctrl_q.pc_write_cond_ne;
  assign i_or_d           = ctrl_q.i_or_d;
  assign mem_read         = ctrl_q.mem_read;
  assign mem_write        = ctrl_q.mem_write;
  assign mem_to_reg       = ctrl_q.mem_to_reg;
  assign reg_dst          = ctrl_q.reg_dst;
  assign reg_write        = ctrl_q.reg_write;
  assign alu_src_a        = ctrl_q.alu_src_a;
  assign alu_src_b        = ctrl_q.alu_src_b;
  assign pc_source        = ctrl_q.pc_source;
  assign alu_op           = ctrl_q.alu_op;
  assign illegal_op       = ctrl_q.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level reference model,
// table-driven directed vectors, randomized opcodes and reset/stall corner cases.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [5:0] alu_op;
    logic       instr_done, illegal_op;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    int         late;
  } vec_t;

  logic       clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic [5:0] opcode = '0;
  logic       pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] alu_op;
  outs_t      act;
  outs_t      exp_q[$];
  int         n_tests = 0, n_fail = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                alu_op, instr_done, illegal_op};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference model: the per-cycle control word sequence for one whole instruction.
  task automatic build_exp(input logic [5:0] op);
    outs_t f;
    exp_q.delete();
    f = '0; f.mem_read = 1; f.ir_write = 1; f.pc_write = 1; f.alu_src_b = 2'b01;
    f.alu_op = 6'b001000; exp_q.push_back(f);
    f = '0; f.alu_src_b = 2'b11; f.alu_op = 6'b001000; exp_q.push_back(f);
    if (op == 6'b100011 || op == 6'b101011) begin
      f = '0; f.alu_src_a = 1; f.alu_src_b = 2'b10; f.alu_op = 6'b100011; exp_q.push_back(f);
      if (op == 6'b100011) begin
        f = '0; f.mem_read = 1; f.i_or_d = 1; exp_q.push_back(f);
        f = '0; f.mem_to_reg = 1; f.reg_write = 1; f.instr_done = 1; exp_q.push_back(f);
      end else begin
        f = '0; f.mem_write = 1; f.i_or_d = 1; f.instr_done = 1; exp_q.push_back(f);
      end
    end else if (op == 6'b000000) begin
      f = '0; f.alu_src_a = 1; exp_q.push_back(f);
      f = '0; f.reg_dst = 1; f.reg_write = 1; f.instr_done = 1; exp_q.push_back(f);
    end else if (op == 6'b000100 || op == 6'b000101) begin
      f = '0; f.alu_src_a = 1; f.alu_op = op; f.pc_source = 2'b01; f.instr_done = 1;
      f.pc_write_cond = (op == 6'b000100); f.pc_write_cond_ne = (op == 6'b000101);
      exp_q.push_back(f);
    end else if (op inside {6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b001011}) begin
      f = '0; f.alu_src_a = 1; f.alu_src_b = 2'b10; f.alu_op = op; exp_q.push_back(f);
      f = '0; f.reg_write = 1; f.instr_done = 1; exp_q.push_back(f);
    end else if (op == 6'b000010) begin
      f = '0; f.pc_write = 1; f.pc_source = 2'b10; f.instr_done = 1; exp_q.push_back(f);
    end else begin
      f = '0; f.illegal_op = 1; exp_q.push_back(f);
    end
  endtask

  // Runs one instruction starting at the next FETCH edge; opcode is valid only in DECODE,
  // other cycles get `late` (or random junk when late < 0). Returns the cycle of the end pulse.
  task automatic run_instr(input logic [5:0] op, input int late, input int abort_after,
                           output int done_cyc);
    build_exp(op);
    done_cyc = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1;
      opcode = (k == 1) ? op : ((late < 0) ? 6'($urandom_range(0, 63)) : 6'(late));
`ifndef MIPS_CTRL_MEM_READY_EN
      mem_ready = 1'($urandom_range(0, 1));
`endif
      @(negedge clk);
      check($sformatf("op%b_cyc%0d", op, k), 32'(act), 32'(exp_q[k]));
      if (done_cyc < 0 && (instr_done || illegal_op)) done_cyc = k + 1;
      if (k == abort_after) return;
    end
  endtask

  vec_t       tbl[10];
  logic [5:0] legal[13];
  int         cyc;
  outs_t      w;

  initial begin
    tbl[0] = '{6'b100011, 5, -1};  // lw
    tbl[1] = '{6'b101011, 4, -1};  // sw
    tbl[2] = '{6'b000000, 4, -1};  // R-type
    tbl[3] = '{6'b000100, 3, -1};  // beq
    tbl[4] = '{6'b000101, 3, 0};   // bne, opcode forced to 0 after DECODE
    tbl[5] = '{6'b001101, 4, -1};  // ori
    tbl[6] = '{6'b001010, 4, -1};  // slti
    tbl[7] = '{6'b000010, 3, -1};  // j
    tbl[8] = '{6'b111111, 3, -1};  // illegal
    tbl[9] = '{6'b000011, 3, -1};  // jal is unsupported
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b001001,
              6'b001100, 6'b001101, 6'b001010, 6'b001011, 6'b000010, 6'b111111};

    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(act), 32'd0);
    rst = 1'b0;
    #1 check("rst_cycle_outputs", 32'(act), 32'd0);

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].late, -1, cyc);
      check($sformatf("cycles_op%b", tbl[i].op), 32'(cyc), 32'(tbl[i].cycles));
    end

    // Reset in the middle of a load: abort, hold RST one cycle, restart at FETCH.
    run_instr(6'b100011, -1, 3, cyc);
    rst = 1'b1;
    #1 check("abort_async_clear", 32'(act), 32'd0);
    @(negedge clk);
    check("abort_held_in_rst", 32'(act), 32'd0);
    rst = 1'b0;
    #1 check("abort_rst_cycle", 32'(act), 32'd0);
    run_instr(6'b000000, -1, -1, cyc);
    check("after_abort_cycles", 32'(cyc), 32'd4);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 1) == 1) ? legal[$urandom_range(0, 12)] : 6'($urandom_range(0, 63));
      run_instr(op, -1, -1, cyc);
      check($sformatf("rand%0d_done_seen", i), 32'(cyc > 0), 32'd1);
    end

`ifdef MIPS_CTRL_MEM_READY_EN
    // FETCH stalled for three cycles: read held, IR/PC loads only on the ready cycle.
    run_instr(6'b000000, -1, -1, cyc);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rd_ir_pc", k), {29'd0, mem_read, ir_write, pc_write}, 32'b100);
    end
    @(posedge clk);
    #1 mem_ready = 1'b1;
    opcode = 6'b000000;
    @(negedge clk);
    check("stall_release_rd_ir_pc", {29'd0, mem_read, ir_write, pc_write}, 32'b111);
    @(negedge clk);
    w = '0; w.alu_src_b = 2'b11; w.alu_op = 6'b001000;
    check("stall_then_decode", 32'(act), 32'(w));
    repeat (2) @(negedge clk);
    check("stall_instr_done", 32'(instr_done), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the mux selects, write strobes and the 6-bit ALUOp consumed by the ALU control decoder. ALUOp 000000 means "decode funct"; any other value is an opcode.
- Sits between the instruction register's opcode field and the shared PC/ALU/register-file/memory datapath.

Parameters:
- OP_W, 6, opcode/ALUOp width; fixed by ISA, must not be overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]; valid from the DECODE cycle onward
- mem_ready  input  1  memory completion; used only with MEM_READY_EN
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero=1 (beq)
- pc_write_cond_ne  output  1  PC load if ALU zero=0 (bne)
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- mem_to_reg  output  1  writeback data select: 1=MDR, 0=ALUOut
- reg_dst  output  1  destination register select: 1=rd, 0=rt
- reg_write  output  1  register file write
- alu_src_a  output  1  ALU A select: 0=PC, 1=A
- alu_src_b  output  2  ALU B select: 00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2
- pc_source  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- alu_op  output  6  to ALU control
- instr_done  output  1  1-cycle pulse in the last state of each instruction
- illegal_op  output  1  1-cycle pulse on an unsupported opcode

Behaviour:
- Moore FSM. Outputs decode state plus op_q only; no combinational path from opcode to any output.
- op_q is a 6-bit register loaded from opcode in DECODE.
- Async reset: state=RST, op_q=0. All outputs are 0 in RST and in any state where they are not listed below.
- RST goes to FETCH on the first clk edge after rst deasserts.
- rst asserted in any state aborts immediately to RST. No strobe asserts while rst=1.
- Per-state outputs and transitions:
  - FETCH: mem_read, ir_write, pc_write, alu_src_b=01, alu_op=001000 -> DECODE
  - DECODE: alu_src_b=11, alu_op=001000. Next state by opcode:
    - 100011/101011 -> MEMADR
    - 000000 -> EXEC
    - 000100/000101 -> BRANCH
    - 001000/001001/001100/001101/001010/001011 -> IEXEC
    - 000010 -> JUMP
    - else -> ILLEGAL
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=100011. op_q=100011 -> MEMRD, else -> MEMWR
  - MEMRD: mem_read, i_or_d -> MEMWB
  - MEMWB: mem_to_reg, reg_write, instr_done -> FETCH
  - MEMWR: mem_write, i_or_d, instr_done -> FETCH
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=000000 -> ALUWB
  - ALUWB: reg_dst, reg_write, instr_done -> FETCH
  - BRANCH: alu_src_a=1, alu_op=op_q, pc_source=01, instr_done. pc_write_cond if op_q=000100, pc_write_cond_ne if op_q=000101 -> FETCH
  - IEXEC: alu_src_a=1, alu_src_b=10, alu_op=op_q -> IWB
  - IWB: reg_write, instr_done (reg_dst=0, mem_to_reg=0) -> FETCH
  - JUMP: pc_write, pc_source=10, instr_done -> FETCH
  - ILLEGAL: illegal_op -> FETCH. No register or memory write; PC is already incremented.
- Cycles per instruction with default build: lw 5; sw, R-type, I-type 4; beq, bne, j 3; illegal 3.
- Unreachable state encodings recover to FETCH on the next edge.
- Only one of pc_write, pc_write_cond and pc_write_cond_ne may be 1 in any cycle.

Optional Feature:
- Macro: MIPS_CTRL_MEM_READY_EN.
- Defined:
  - FETCH, MEMRD and MEMWR hold while mem_ready=0.
  - mem_read/mem_write and i_or_d stay asserted during the hold.
  - In FETCH, ir_write and pc_write assert only in the cycle mem_ready=1, and the state advances on that edge.
  - MEMWR asserts instr_done only in its mem_ready=1 cycle.
- Undefined: mem_ready is ignored and every state lasts exactly one cycle.

Test Plan:
- rst=1 mid-MEMRD, then release -> one RST cycle with all outputs 0, then FETCH with mem_read=1, ir_write=1, pc_write=1, alu_op=001000.
- Opcode 100011 -> states FETCH, DECODE, MEMADR (alu_op=100011), MEMRD (i_or_d=1), MEMWB (reg_write=1, mem_to_reg=1); instr_done pulses in cycle 5 only.
- Opcode 000000 -> EXEC with alu_op=000000, then ALUWB with reg_dst=1, reg_write=1; 4 cycles total.
- Opcode 000101 -> BRANCH with alu_op=000101, pc_write_cond_ne=1, pc_write_cond=0, pc_source=01; opcode changed to 000000 during BRANCH does not change alu_op.
- Opcode 001101 -> IEXEC alu_op=001101, alu_src_b=10, then IWB with reg_write=1, reg_dst=0. Opcode 111111 -> illegal_op pulses once with no write strobes, then FETCH.
- With MIPS_CTRL_MEM_READY_EN, mem_ready=0 for 3 cycles in FETCH -> mem_read held 4 cycles; ir_write and pc_write only in the 4th cycle; DECODE follows.
